// File: rtl/shift_issue_reg.sv
// -----------------------------------------------------------------------------
// shift_issue_reg
//
// ID/EX issue register in front of the execute-stage shifter. Decoded shift
// operands are captured under a valid/ready handshake, the effective shift
// amount is resolved at capture time, and the entry is presented registered to
// the shifter one cycle later. A main register plus one skid register form a
// 2-entry FIFO, so in_ready can be registered while still sustaining one
// transfer per cycle. A synchronous flush drops everything buffered, and a
// saturating counter records back-pressure cycles.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1 (push = in_valid & in_ready, pop = out_valid & out_ready). A producer
// holding valid=1 keeps its payload stable until the transfer; out_* stay
// stable while out_valid=1 and out_ready=0.
//
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   flush         synchronous discard of all buffered entries
//   in_valid/in_ready, in_rs1, in_rs2, in_shamt, in_imm_sel, in_op, in_rd
//                 upstream entry
//   out_valid/out_ready, out_a, out_b, out_shamt, out_op, out_rd
//                 entry presented to the shifter
//   stall_cnt     saturating count of cycles with out_valid=1 and out_ready=0
//   dbg_state     current FSM state (0 EMPTY, 1 BUSY, 2 FULL)
// -----------------------------------------------------------------------------
module shift_issue_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_shamt,
  input  logic             in_imm_sel,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [4:0]       out_shamt,
  output logic [1:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      shamt;
    logic [1:0]      op;
    logic [4:0]      rd;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  entry_t           r_main;
  entry_t           r_skid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic   w_push;
  logic   w_pop;
  entry_t w_in_entry;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Shift amount is resolved here, so a stored entry is immune to later
  // changes of in_rs2 / in_shamt / in_imm_sel.
  always_comb begin
    w_in_entry       = '0;
    w_in_entry.a     = in_rs1;
    w_in_entry.b     = in_rs2;
    w_in_entry.shamt = in_imm_sel ? in_shamt : in_rs2[4:0];
    w_in_entry.op    = in_op;
    w_in_entry.rd    = in_rd;
  end

  // Flags are computed from the next state so they come straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Counted from the outputs seen this cycle; flush does not clear it.
      if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (flush) begin
        // Data registers keep stale contents; out_valid=0 qualifies them.
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
      end else begin
        unique case (r_state)
          ST_EMPTY: begin
            if (w_push) begin
              r_main      <= w_in_entry;
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (w_push && w_pop) begin
              r_main <= w_in_entry;
            end else if (w_push) begin
              // Main is stalled; park the younger entry in the skid register.
              r_skid     <= w_in_entry;
              r_state    <= ST_FULL;
              r_in_ready <= 1'b0;
            end else if (w_pop) begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            // in_ready is 0 here, so only a pop can move the state.
            if (w_pop) begin
              r_main     <= r_skid;
              r_state    <= ST_BUSY;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_a     = r_main.a;
  assign out_b     = r_main.b;
  assign out_shamt = r_main.shamt;
  assign out_op    = r_main.op;
  assign out_rd    = r_main.rd;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_issue_reg.sv
module tb_shift_issue_reg;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic            flush      = 1'b0;
  logic            in_valid   = 1'b0;
  logic [XLEN-1:0] in_rs1     = '0;
  logic [XLEN-1:0] in_rs2     = '0;
  logic [4:0]      in_shamt   = '0;
  logic            in_imm_sel = 1'b0;
  logic [1:0]      in_op      = '0;
  logic [4:0]      in_rd      = '0;
  logic            out_ready  = 1'b0;

  // ---------------- main DUT (CNT_W=16) ----------------
  logic            in_ready, out_valid;
  logic [XLEN-1:0] out_a, out_b;
  logic [4:0]      out_shamt, out_rd;
  logic [1:0]      out_op, dbg_state;
  logic [15:0]     stall_cnt;

  shift_issue_reg #(.XLEN(XLEN), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_shamt(in_shamt),
    .in_imm_sel(in_imm_sel), .in_op(in_op), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
    .out_op(out_op), .out_rd(out_rd),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- narrow-counter DUT (CNT_W=2) ----------------
  logic            in_ready2, out_valid2;
  logic [XLEN-1:0] out_a2, out_b2;
  logic [4:0]      out_shamt2, out_rd2;
  logic [1:0]      out_op2, dbg_state2;
  logic [1:0]      stall_cnt2;

  shift_issue_reg #(.XLEN(XLEN), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_shamt(in_shamt),
    .in_imm_sel(in_imm_sel), .in_op(in_op), .in_rd(in_rd),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_a(out_a2), .out_b(out_b2), .out_shamt(out_shamt2),
    .out_op(out_op2), .out_rd(out_rd2),
    .stall_cnt(stall_cnt2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                       input logic [4:0] sh, input logic isel, input logic [1:0] op,
                       input logic [4:0] rd);
    in_valid   = v;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_shamt   = sh;
    in_imm_sel = isel;
    in_op      = op;
    in_rd      = rd;
  endtask

  int n_sent;
  int n_got;

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_a",     out_a,     0);
    check("rst_stall",     stall_cnt, 0);
    check("rst_state",     dbg_state, 0);
    rst = 1'b0;

    // ---- 1: immediate shamt, SRA ----
    out_ready = 1'b1;
    drive(1, 32'h8000_0010, 32'h0000_001F, 5'd4, 1, 2'b10, 5'd1);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_a",     out_a,     32'h8000_0010);
    check("t1_out_shamt", out_shamt, 4);
    check("t1_out_op",    out_op,    2'b10);
    check("t1_out_rd",    out_rd,    1);

    // ---- 2: shamt from rs2[4:0], back-to-back with a pop ----
    drive(1, 32'h0000_0011, 32'h0000_0123, 5'd7, 0, 2'b01, 5'd2);
    tick();
    check("t2_out_valid", out_valid, 1);
    check("t2_out_shamt", out_shamt, 5'h03);
    check("t2_out_b",     out_b,     32'h0000_0123);
    check("t2_out_a",     out_a,     32'h0000_0011);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t2_drain_valid", out_valid, 0);
    check("t2_no_stall",    stall_cnt, 0);

    // ---- 3: back-pressure fills the skid buffer ----
    out_ready = 1'b0;
    drive(1, 32'h0000_000A, 0, 5'd1, 1, 2'b00, 5'd10);
    tick();
    check("t3_a_in_ready", in_ready, 1);
    drive(1, 32'h0000_000B, 0, 5'd2, 1, 2'b11, 5'd11);
    tick();
    check("t3_full_in_ready", in_ready, 0);
    check("t3_full_state",    dbg_state, 2);
    check("t3_hold_a",        out_a, 32'h0000_000A);
    drive(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    tick();
    check("t3_hold_a2",   out_a,     32'h0000_000A);
    check("t3_hold_rd",   out_rd,    10);
    check("t3_stall_cnt", stall_cnt, 2);
    out_ready = 1'b1;
    tick();
    check("t3_b_out",      out_a,    32'h0000_000B);
    check("t3_b_op",       out_op,   2'b11);
    check("t3_b_shamt",    out_shamt, 2);
    check("t3_b_in_ready", in_ready, 1);
    tick();
    check("t3_empty", out_valid, 0);
    check("t3_stall_hold", stall_cnt, 2);

    // ---- 4a: streaming 8 entries, one per cycle ----
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 0, 5'(i), 1, 2'b01, 5'(i));
      tick();
      check("t4_stream_valid", out_valid, 1);
      check("t4_stream_data",  out_a, 32'h100 + i);
      check("t4_stream_ready", in_ready, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("t4_stream_end", out_valid, 0);

    // ---- 4b: toggled out_ready, scoreboard ordering ----
    n_sent = 0;
    n_got  = 0;
    for (int c = 0; c < 40; c++) begin
      if (n_got == 8) break;
      out_ready = (c < 16) ? ((c % 2) == 1) : 1'b1;
      drive(n_sent < 8, 32'h200 + n_sent, 0, 5'd3, 1, 2'b00, 5'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_rs1);
        n_sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("t4_toggle_extra", out_a, 32'hFFFF_FFFF);
        else check("t4_toggle_data", out_a, exp_q.pop_front());
        n_got++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4_toggle_sent", n_sent, 8);
    check("t4_toggle_got",  n_got,  8);
    check("t4_toggle_left", exp_q.size(), 0);
    out_ready = 1'b1;
    tick();
    check("t4_toggle_empty", out_valid, 0);

    // ---- 5: flush in FULL state with a push and pop offered ----
    out_ready = 1'b0;
    drive(1, 32'h0000_00C0, 0, 0, 1, 0, 0);
    tick();
    drive(1, 32'h0000_00D0, 0, 0, 1, 0, 0);
    tick();
    check("t5_full", in_ready, 0);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1, 32'h0000_00E0, 0, 0, 1, 0, 0);
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready, 1);
    check("t5_flush_state", dbg_state, 0);
    repeat (3) tick();
    check("t5_no_delivery", out_valid, 0);

    // ---- 6: saturation with CNT_W=2, flush keeps count, async reset ----
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    out_ready = 1'b0;
    drive(1, 32'h0000_00F0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (6) tick();
    check("t6_valid2",      out_valid2, 1);
    check("t6_sat_cnt2",    stall_cnt2, 3);
    check("t6_cnt16",       stall_cnt,  6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_keep2", stall_cnt2, 3);
    check("t6_flush_cnt16", stall_cnt,  7);
    check("t6_flush_valid", out_valid2, 0);
    drive(1, 32'h0000_0F00, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t6_repush_valid", out_valid2, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_async_cnt2",   stall_cnt2, 0);
    check("t6_async_valid2", out_valid2, 0);
    check("t6_async_cnt16",  stall_cnt,  0);
    check("t6_async_valid",  out_valid,  0);
    check("t6_async_ready",  in_ready,   1);
    #2 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog: the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
